// File: rtl/reg_access_master_if.sv
// Host command/response and register-bus signals of reg_access_master.
// master modport: the access master (host command in, response out, drives the register bus).
// slave modport:  the surroundings (host side plus register responder).
interface reg_access_master_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
);
    localparam int unsigned BW = 4 * DATA_WIDTH;

    // host command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wnr;
    logic [1:0]            cmd_size;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [BW-1:0]         cmd_wdata;
    // host response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [BW-1:0]         rsp_rdata;
    logic                  rsp_error;
    // register bus
    logic [1:0]            req;
    logic                  wnr;
    logic [ADDR_WIDTH-1:0] address;
    logic [BW-1:0]         data_in;
    logic                  ack;
    logic [BW-1:0]         data_out;

    modport master (
        input  cmd_valid, cmd_wnr, cmd_size, cmd_addr, cmd_wdata, rsp_ready, ack, data_out,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, req, wnr, address, data_in
    );

    modport slave (
        output cmd_valid, cmd_wnr, cmd_size, cmd_addr, cmd_wdata, rsp_ready, ack, data_out,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, req, wnr, address, data_in
    );
endinterface

// File: rtl/reg_access_master.sv
// Register access master: takes one host command at a time, checks it, issues a
// one-cycle request on the register bus, waits for ack (with timeout) and returns
// a response held until the host accepts it.
// Ports: clk, reset (synchronous, active high), bus (reg_access_master_if.master:
// cmd_* in, rsp_* out, req/wnr/address/data_in out, ack/data_out in).
module reg_access_master #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    reg_access_master_if.master        bus
);
    localparam int unsigned BW  = 4 * DATA_WIDTH;
    localparam int unsigned AW1 = ADDR_WIDTH + 1;
    localparam int unsigned CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_nxt;
    logic [1:0]            req_q, req_d, size_q, size_d;
    logic                  wnr_q, wnr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BW-1:0]         wdata_q, wdata_d, rdata_q, rdata_d, rd_mask;
    logic                  rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            nregs;
    logic [AW1-1:0]        last_addr;
    logic                  accept, legal, timed_out;

    // command decode: register count and range check on the last touched address
    always_comb begin
        case (bus.cmd_size)
            2'd2:    nregs = 3'd2;
            2'd3:    nregs = 3'd4;
            default: nregs = 3'd1;
        endcase
    end

    assign last_addr = {1'b0, bus.cmd_addr} + AW1'(nregs) - AW1'(1);
    assign legal     = (bus.cmd_size != 2'd0) && !last_addr[ADDR_WIDTH];
    assign accept    = bus.cmd_valid && bus.cmd_ready;
    assign timed_out = (cnt_q >= CW'(TIMEOUT));

    // read data keeps only the bytes that were requested
    always_comb begin
        case (size_q)
            2'd1:    rd_mask = BW'({DATA_WIDTH{1'b1}});
            2'd2:    rd_mask = BW'({(2 * DATA_WIDTH){1'b1}});
            default: rd_mask = {BW{1'b1}};
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_q       <= '0;
            size_q      <= '0;
            wnr_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state       <= state_nxt;
            req_q       <= req_d;
            size_q      <= size_d;
            wnr_q       <= wnr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // next-state logic; ack on the timeout cycle still counts as success
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = legal ? WAIT : RESP;
            WAIT:    if (bus.ack || timed_out) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // next values of the registered outputs; req defaults to zero so it pulses one cycle
    always_comb begin
        req_d       = '0;
        size_d      = size_q;
        wnr_d       = wnr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    size_d = bus.cmd_size;
                    if (legal) begin
                        req_d   = bus.cmd_size;
                        wnr_d   = bus.cmd_wnr;
                        addr_d  = bus.cmd_addr;
                        wdata_d = bus.cmd_wdata;
                        cnt_d   = CW'(1);
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rdata_d     = '0;
                        cnt_d       = '0;
                    end
                end
            end
            WAIT: begin
                if (bus.ack) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rdata_d     = wnr_q ? '0 : (bus.data_out & rd_mask);
                end else if (timed_out) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rdata_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready = (state == IDLE) && !reset;
    assign bus.req       = req_q;
    assign bus.wnr       = wnr_q;
    assign bus.address   = addr_q;
    assign bus.data_in   = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.rsp_rdata = rdata_q;
endmodule
